fetch_controller: RTL and testbench

- Sequences the byte-addressed instruction memory for the pipelined processor's IF stage.
- Generates the fetch address stream (PC, PC+4, …) and issues read requests.
- Buffers returned instructions with their PCs in a small prefetch FIFO and hands them to IF/ID over a valid/ready handshake.
- Handles branch/jump redirects by flushing buffered and in-flight fetches. Sits between the PC/branch logic and the instruction memory.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 67 ++++++
 rtl/fetch_controller.sv | 113 +++++++++++
 tb/tb_fetch_controller.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch front end.
package fetch_pkg;

  // Bytes per instruction word; the PC advances by this amount per issue.
  localparam int unsigned INSTR_BYTES = 4;

  // Canonical NOP (addi x0, x0, 0), injected by IF/ID when it has nothing valid.
  localparam logic [31:0] NOP = 32'h0000_0013;

  // Fetch sequencer states.
  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t BOOT  = 2'd0;
  localparam fetch_state_t RUN   = 2'd1;
  localparam fetch_state_t FLUSH = 2'd2;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: DEPTH entries of {instr, pc}, synchronous push/pop/flush.
// Flush empties the queue but leaves storage untouched; the head output is
// only meaningful while valid is high.
module fetch_fifo #(
  parameter int unsigned      DEPTH      = 4,
  parameter int unsigned      WIDTH      = 42,
  parameter logic [WIDTH-1:0] RESET_WORD = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  input  logic                     flush,
  output logic                     valid,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL    = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push, do_pop;

  // A push into a full queue is accepted only when a pop frees a slot.
  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q != FULL) || do_pop);

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= rd_ptr_q;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage; cleared on reset so the head shows the reset word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= RESET_WORD;
    end else if (do_push && !flush) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign valid = (count_q != '0);
  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_controller.sv
// IF-stage fetch sequencer: issues word-aligned reads to a 1-cycle-latency
// instruction memory, buffers {instr, pc} in a prefetch FIFO and presents the
// head to IF/ID over valid/ready. A redirect flushes buffered and in-flight work.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 10,
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  input  logic              if_ready
);

  localparam int unsigned       CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(INSTR_BYTES);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] inflight_pc_q;
  logic              inflight_q;
  logic              kill_q;
  logic [CNT_W-1:0]  occupancy;
  logic              credit;
  logic              push, pop;
  logic              fifo_valid;
  logic [DATA_W+ADDR_W-1:0] head;

  // Credit uses registered counts only, so a same-cycle pop never frees a slot
  // for an issue in that cycle.
  assign credit   = (occupancy + CNT_W'(inflight_q)) < DEPTH_C;
  assign imem_req = (state_q == RUN) && fetch_en && !redirect && credit;
  assign imem_addr = pc_q;

  // Responses landing during a redirect (or flagged killed) are dropped.
  assign push = inflight_q && !kill_q && !redirect;
  assign pop  = fifo_valid && if_ready && !redirect;

  // Next-state: redirect overrides everything and always lands in FLUSH.
  always_comb begin
    state_d = state_q;
    if (redirect) begin
      state_d = FLUSH;
    end else begin
      case (state_q)
        BOOT:    state_d = RUN;
        RUN:     state_d = RUN;
        FLUSH:   state_d = RUN;
        default: state_d = BOOT;
      endcase
    end
  end

  // Next PC: redirect target (word aligned) or sequential advance on issue.
  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      pc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
    end else if (imem_req) begin
      pc_d = pc_q + PC_STEP;
    end
  end

  // Sequencer state, PC and single-entry in-flight tracking.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= RESET_PC;
      kill_q        <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inflight_q <= imem_req;
      if (imem_req) inflight_pc_q <= pc_q;
      kill_q     <= redirect;
    end
  end

  fetch_fifo #(
    .DEPTH      (DEPTH),
    .WIDTH      (DATA_W + ADDR_W),
    .RESET_WORD ({{DATA_W{1'b0}}, RESET_PC})
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({imem_rdata, inflight_pc_q}),
    .pop   (pop),
    .flush (redirect),
    .valid (fifo_valid),
    .head  (head),
    .count (occupancy)
  );

  assign if_valid = fifo_valid;
  assign if_instr = head[DATA_W+ADDR_W-1:ADDR_W];
  assign if_pc    = head[ADDR_W-1:0];

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: directed scenarios plus random
// traffic, all compared cycle by cycle against a queue-based reference model.
module tb_fetch_controller;

  localparam int unsigned       ADDR_W   = 10;
  localparam int unsigned       DATA_W   = 32;
  localparam int unsigned       DEPTH    = 4;
  localparam logic [ADDR_W-1:0] RESET_PC = '0;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              fetch_en = 1'b0;
  logic              redirect = 1'b0;
  logic [ADDR_W-1:0] redirect_pc = '0;
  logic              if_ready = 1'b0;
  logic              imem_req, if_valid;
  logic [ADDR_W-1:0] imem_addr, if_pc;
  logic [DATA_W-1:0] imem_rdata, if_instr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  // Instruction memory: word k lives at byte address 4k, 1-cycle read latency.
  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return DATA_W'(a >> 2);
  endfunction

  logic [ADDR_W-1:0] mem_addr_q = '0;
  always @(posedge clk) mem_addr_q <= imem_addr;
  assign imem_rdata = mem_word(mem_addr_q);

  fetch_controller #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_en    (fetch_en),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .if_ready    (if_ready)
  );

  // Reference model: a queue of delivered-to-be entries, one outstanding read,
  // the next fetch address, and a flag for "no issue allowed this cycle".
  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] pc;
  } ent_t;

  ent_t              m_q[$];
  logic              m_infl;
  logic [ADDR_W-1:0] m_infl_pc;
  logic [ADDR_W-1:0] m_pc;
  logic              m_quiet;

  // Values observed at the most recent sample point.
  logic              s_req, s_valid;
  logic [ADDR_W-1:0] s_addr, s_pc;
  logic [DATA_W-1:0] s_instr;

  function automatic void model_reset();
    m_q.delete();
    m_infl    = 1'b0;
    m_infl_pc = RESET_PC;
    m_pc      = RESET_PC;
    m_quiet   = 1'b1;
  endfunction

  // One clock: sample and compare on the falling edge, advance model on the rising edge.
  task automatic tick();
    logic er;
    @(negedge clk);
    s_req   = imem_req;
    s_addr  = imem_addr;
    s_valid = if_valid;
    s_pc    = if_pc;
    s_instr = if_instr;
    er = !m_quiet && fetch_en && !redirect && ((m_q.size() + (m_infl ? 1 : 0)) < DEPTH);
    checks++;
    if (imem_req !== er) begin
      errors++;
      $display("FAIL imem_req cyc=%0d got %b expected %b", cyc, imem_req, er);
    end
    checks++;
    if (imem_addr !== m_pc) begin
      errors++;
      $display("FAIL imem_addr cyc=%0d got %h expected %h", cyc, imem_addr, m_pc);
    end
    checks++;
    if (if_valid !== (m_q.size() != 0)) begin
      errors++;
      $display("FAIL if_valid cyc=%0d got %b expected %b", cyc, if_valid, m_q.size() != 0);
    end
    if (m_q.size() != 0) begin
      checks++;
      if (if_pc !== m_q[0].pc || if_instr !== m_q[0].instr) begin
        errors++;
        $display("FAIL if_head cyc=%0d got pc=%h instr=%h expected pc=%h instr=%h",
                 cyc, if_pc, if_instr, m_q[0].pc, m_q[0].instr);
      end
    end
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      model_reset();
    end else if (redirect) begin
      m_q.delete();
      m_infl  = 1'b0;
      m_pc    = redirect_pc & ~ADDR_W'(3);
      m_quiet = 1'b1;
    end else begin
      if (m_q.size() != 0 && if_ready) void'(m_q.pop_front());
      if (m_infl) m_q.push_back('{instr: mem_word(m_infl_pc), pc: m_infl_pc});
      m_infl    = er;
      m_infl_pc = m_pc;
      if (er) m_pc = m_pc + ADDR_W'(4);
      m_quiet   = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    redirect = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fetch_en = 1'b0; if_ready = 1'b0; redirect = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    tick();
    checks++;
    if (s_instr !== '0 || s_pc !== RESET_PC) begin
      errors++;
      $display("FAIL reset_head got instr=%h pc=%h expected instr=0 pc=%h", s_instr, s_pc, RESET_PC);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    do_reset();
    fetch_en = 1'b1; if_ready = 1'b1;
    tick();
    checks++;
    if (s_req !== 1'b0) begin
      errors++; $display("FAIL boot_no_req got %b expected 0", s_req);
    end
    tick();
    checks++;
    if (s_req !== 1'b1 || s_addr !== '0) begin
      errors++; $display("FAIL first_req got req=%b addr=%h expected req=1 addr=0", s_req, s_addr);
    end
    tick();
    tick();
    checks++;
    if (s_valid !== 1'b1 || s_pc !== '0) begin
      errors++; $display("FAIL first_valid got valid=%b pc=%h expected valid=1 pc=0", s_valid, s_pc);
    end
    for (int i = 1; i <= 8; i++) begin
      tick();
      checks++;
      if (s_valid !== 1'b1 || s_pc !== ADDR_W'(4 * i)) begin
        errors++;
        $display("FAIL stream_pc got valid=%b pc=%h expected valid=1 pc=%h", s_valid, s_pc, 4 * i);
      end
    end
  endtask

  task automatic test_stall();
    int nreq;
    int ndel;
    logic [ADDR_W-1:0] addrs[4];
    logic seen_req;
    logic [ADDR_W-1:0] resume_addr;
    do_reset();
    fetch_en = 1'b1; if_ready = 1'b0;
    nreq = 0;
    repeat (11) begin
      tick();
      if (s_req) begin
        if (nreq < 4) addrs[nreq] = s_addr;
        nreq++;
      end
      if (s_valid) begin
        checks++;
        if (s_pc !== '0) begin
          errors++; $display("FAIL stall_hold got pc=%h expected 0", s_pc);
        end
      end
    end
    checks++;
    if (nreq != 4) begin
      errors++; $display("FAIL stall_req_count got %0d expected 4", nreq);
    end
    for (int i = 0; i < 4 && i < nreq; i++) begin
      checks++;
      if (addrs[i] !== ADDR_W'(4 * i)) begin
        errors++; $display("FAIL stall_addr got %h expected %h", addrs[i], 4 * i);
      end
    end
    if_ready = 1'b1;
    ndel = 0;
    seen_req = 1'b0;
    resume_addr = '0;
    repeat (8) begin
      tick();
      if (s_req && !seen_req) begin
        seen_req = 1'b1;
        resume_addr = s_addr;
      end
      if (s_valid) begin
        checks++;
        if (s_pc !== ADDR_W'(4 * ndel)) begin
          errors++; $display("FAIL drain_order got %h expected %h", s_pc, 4 * ndel);
        end
        ndel++;
      end
    end
    checks++;
    if (!seen_req || resume_addr !== ADDR_W'(16)) begin
      errors++; $display("FAIL resume_addr got seen=%b addr=%h expected 010", seen_req, resume_addr);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    fetch_en = 1'b1; if_ready = 1'b0;
    for (int n = 0; n < 20 && !(m_q.size() == 3 && m_infl); n++) tick();
    checks++;
    if (!(m_q.size() == 3 && m_infl)) begin
      errors++; $display("FAIL redirect_setup got occ=%0d infl=%b expected 3/1", m_q.size(), m_infl);
    end
    redirect = 1'b1; redirect_pc = ADDR_W'('h106);
    tick();
    redirect = 1'b0;
    tick();
    checks++;
    if (s_valid !== 1'b0 || s_req !== 1'b0) begin
      errors++; $display("FAIL flush_cycle got valid=%b req=%b expected 0/0", s_valid, s_req);
    end
    tick();
    checks++;
    if (s_req !== 1'b1 || s_addr !== ADDR_W'('h104)) begin
      errors++; $display("FAIL redirect_req got req=%b addr=%h expected 1/104", s_req, s_addr);
    end
    if_ready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      tick();
      if (s_valid) break;
    end
    checks++;
    if (s_valid !== 1'b1 || s_pc !== ADDR_W'('h104) || s_instr !== DATA_W'('h41)) begin
      errors++;
      $display("FAIL redirect_first got valid=%b pc=%h instr=%h expected 1/104/41",
               s_valid, s_pc, s_instr);
    end
  endtask

  task automatic test_double_redirect();
    int stale;
    logic got;
    logic [ADDR_W-1:0] first;
    do_reset();
    fetch_en = 1'b1; if_ready = 1'b1;
    repeat (6) tick();
    redirect = 1'b1; redirect_pc = ADDR_W'('h040);
    tick();
    redirect_pc = ADDR_W'('h080);
    tick();
    redirect = 1'b0;
    stale = 0; got = 1'b0; first = '0;
    repeat (8) begin
      tick();
      if (s_valid) begin
        if (s_pc >= ADDR_W'('h040) && s_pc < ADDR_W'('h080)) stale++;
        if (!got) begin
          got = 1'b1;
          first = s_pc;
        end
      end
    end
    checks++;
    if (stale != 0) begin
      errors++; $display("FAIL double_redirect_stale got %0d expected 0", stale);
    end
    checks++;
    if (!got || first !== ADDR_W'('h080)) begin
      errors++; $display("FAIL double_redirect_first got got=%b pc=%h expected 080", got, first);
    end
  endtask

  task automatic test_wrap();
    logic [ADDR_W-1:0] exp_w[4];
    logic [ADDR_W-1:0] reqs[4];
    logic [ADDR_W-1:0] dels[4];
    int nr;
    int nd;
    exp_w = '{ADDR_W'('h3F8), ADDR_W'('h3FC), ADDR_W'('h000), ADDR_W'('h004)};
    do_reset();
    fetch_en = 1'b1; if_ready = 1'b1;
    repeat (2) tick();
    redirect = 1'b1; redirect_pc = ADDR_W'('h3F8);
    tick();
    redirect = 1'b0;
    nr = 0; nd = 0;
    repeat (10) begin
      tick();
      if (s_req && nr < 4) begin reqs[nr] = s_addr; nr++; end
      if (s_valid && nd < 4) begin dels[nd] = s_pc; nd++; end
    end
    checks++;
    if (nr != 4 || nd != 4) begin
      errors++; $display("FAIL wrap_count got req=%0d del=%0d expected 4/4", nr, nd);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ((i < nr && reqs[i] !== exp_w[i]) || (i < nd && dels[i] !== exp_w[i])) begin
        errors++;
        $display("FAIL wrap_seq idx=%0d got req=%h pc=%h expected %h", i, reqs[i], dels[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    fetch_en = 1'b1; if_ready = 1'b0;
    for (int n = 0; n < 20 && !(m_q.size() == 3 && m_infl); n++) tick();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (s_req !== 1'b0 || s_addr !== RESET_PC || s_valid !== 1'b0 ||
        s_instr !== '0 || s_pc !== RESET_PC) begin
      errors++;
      $display("FAIL reset_mid_outputs got req=%b addr=%h valid=%b instr=%h pc=%h expected reset values",
               s_req, s_addr, s_valid, s_instr, s_pc);
    end
    rst_n = 1'b1; if_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      tick();
      if (s_valid) break;
    end
    checks++;
    if (s_valid !== 1'b1 || s_pc !== RESET_PC) begin
      errors++; $display("FAIL reset_mid_restart got valid=%b pc=%h expected 1/%h", s_valid, s_pc, RESET_PC);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 800; n++) begin
      fetch_en    = ($urandom_range(0, 3) != 0);
      if_ready    = ($urandom_range(0, 2) != 0);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = ADDR_W'($urandom);
      rst_n       = ($urandom_range(0, 99) != 0);
      tick();
    end
    rst_n = 1'b1; redirect = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_double_redirect();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
